// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle controller and datapath:
// FSM states, ALU operation classes, opcode/funct fields and ALU control codes.
package mc_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // bit2 inverts B and sets carry-in; bits1:0 pick the result
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps the controller's operation class and the R-type funct
// field onto the 3-bit ALU control code.
module aludec
    import mc_controller_pkg::*;
(
    input  aluop_e     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset controller: Moore FSM whose state alone selects the
// datapath controls; only pcen (via zero) and alucontrol (via funct) see inputs.
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter bit ADDI_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    state_e state_q, state_d;
    aluop_e aluop;
    logic   pcwrite;
    logic   branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = ADDI_EN ? S_ADDIEX : S_FETCH;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            // MEMWB, MEMWR, ALUWB, BEQ, ADDIWB, JUMP and the unused codes
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = ALUOP_ADD;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwrite = 1'b1;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
            end
            S_DECODE:  alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD:   iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQ: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB:  regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcen  = pcwrite | (branch & zero);
    assign state = state_q;

    aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: expected per-cycle state and control
// vectors are queued per instruction and compared on the falling clock edge.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;

    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    logic       pcen0, iord0, memwrite0, irwrite0, regdst0, memtoreg0, regwrite0, alusrca0;
    logic [1:0] alusrcb0, pcsrc0;
    logic [2:0] alucontrol0;
    logic [3:0] state0;

    int vectors = 0;
    int errs    = 0;

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic [14:0] ctl;
        bit         chk0;
        logic [3:0] st0;
        logic [14:0] ctl0;
    } rec_t;

    rec_t sbq[$];

    always #5 clk = ~clk;

    mc_controller #(.ADDI_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .state(state)
    );

    mc_controller #(.ADDI_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen0), .iord(iord0), .memwrite(memwrite0), .irwrite(irwrite0),
        .regdst(regdst0), .memtoreg(memtoreg0), .regwrite(regwrite0),
        .alusrca(alusrca0), .alusrcb(alusrcb0), .pcsrc(pcsrc0),
        .alucontrol(alucontrol0), .state(state0)
    );

    wire [14:0] ctl  = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                        alusrca, alusrcb, pcsrc, alucontrol};
    wire [14:0] ctl0 = {pcen0, iord0, memwrite0, irwrite0, regdst0, memtoreg0, regwrite0,
                        alusrca0, alusrcb0, pcsrc0, alucontrol0};

    function automatic logic [2:0] f2alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,alucontrol}
    function automatic logic [14:0] exp_ctl(input int st, input logic [5:0] f, input logic z);
        case (st)
            0:  return 15'b1_0_0_1_0_0_0_0_01_00_010;
            1:  return 15'b0_0_0_0_0_0_0_0_11_00_010;
            2:  return 15'b0_0_0_0_0_0_0_1_10_00_010;
            3:  return 15'b0_1_0_0_0_0_0_0_00_00_010;
            4:  return 15'b0_0_0_0_0_1_1_0_00_00_010;
            5:  return 15'b0_1_1_0_0_0_0_0_00_00_010;
            6:  return {12'b0_0_0_0_0_0_0_1_00_00, f2alu(f)};
            7:  return 15'b0_0_0_0_1_0_1_0_00_00_010;
            8:  return {z, 14'b0_0_0_0_0_0_1_00_01_110};
            9:  return 15'b0_0_0_0_0_0_0_1_10_00_010;
            10: return 15'b0_0_0_0_0_0_1_0_00_00_010;
            11: return 15'b1_0_0_0_0_0_0_0_00_10_010;
            default: return 15'h7fff;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int st, input bit c0 = 1'b0, input int st0 = 0);
        rec_t r;
        r.tag  = tag;
        r.st   = st[3:0];
        r.ctl  = exp_ctl(st, funct, zero);
        r.chk0 = c0;
        r.st0  = st0[3:0];
        r.ctl0 = exp_ctl(st0, funct, zero);
        sbq.push_back(r);
    endtask

    task automatic cmp_one();
        rec_t r;
        r = sbq.pop_front();
        chk({r.tag, ".st"},  {28'd0, state}, {28'd0, r.st});
        chk({r.tag, ".ctl"}, {17'd0, ctl},   {17'd0, r.ctl});
        if (r.chk0) begin
            chk({r.tag, ".st0"},  {28'd0, state0}, {28'd0, r.st0});
            chk({r.tag, ".ctl0"}, {17'd0, ctl0},   {17'd0, r.ctl0});
        end
    endtask

    // First record is compared right away, the rest one per cycle.
    task automatic drain();
        cmp_one();
        while (sbq.size() > 0) begin
            @(negedge clk);
            cmp_one();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic run(input string tag, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input int n, input logic [47:0] trace);
        op = o; funct = f; zero = z;
        do_reset();
        for (int i = 0; i < n; i++) push(tag, int'(trace[47-4*i -: 4]));
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] fl [6];
        fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};

        // reset state, both instances
        #3;
        push("rst", 0, 1'b1, 0);
        cmp_one();
        rst_n = 1'b1;

        run("lw",  6'b100011, 6'd0, 1'b0, 6, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 24'd0});
        run("sw",  6'b101011, 6'd0, 1'b0, 5, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 28'd0});
        foreach (fl[k])
            run($sformatf("rtype%0d", k), 6'b000000, fl[k], 1'b0, 5,
                {4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 28'd0});
        run("beq_z1", 6'b000100, 6'd0, 1'b1, 4, {4'd0, 4'd1, 4'd8, 4'd0, 32'd0});
        run("beq_z0", 6'b000100, 6'd0, 1'b0, 4, {4'd0, 4'd1, 4'd8, 4'd0, 32'd0});
        run("j",      6'b000010, 6'd0, 1'b0, 4, {4'd0, 4'd1, 4'd11, 4'd0, 32'd0});
        run("bad",    6'b111111, 6'd0, 1'b0, 4, {4'd0, 4'd1, 4'd0, 4'd1, 32'd0});

        // addi: enabled instance runs 0,1,9,10,0; disabled one falls back to fetch
        op = 6'b001000; funct = 6'd0; zero = 1'b0;
        do_reset();
        push("addi", 0, 1'b1, 0);
        push("addi", 1, 1'b1, 1);
        push("addi", 9, 1'b1, 0);
        push("addi", 10);
        push("addi", 0);
        drain();

        // reset pulse in the middle of EXECUTE
        op = 6'b000000; funct = 6'b100010;
        do_reset();
        push("mid", 0); push("mid", 1); push("mid", 6);
        drain();
        #1 rst_n = 1'b0;
        #1 push("mid_rst", 0);
        cmp_one();
        rst_n = 1'b1;
        @(negedge clk);
        push("mid_after", 1);
        cmp_one();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter ADDI_EN, default 1; 1 decodes addi (op 001000), 0 treats it as unsupported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 op  input  6  instruction opcode field from the instruction register.
REQ-005 funct  input  6  R-type function field from the instruction register.
REQ-006 zero  input  1  ALU zero flag (result == 0), same cycle as the ALU result.
REQ-007 pcen  output  1  PC register write enable.
REQ-008 iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 memwrite  output  1  data memory write strobe.
REQ-010 irwrite  output  1  instruction register load.
REQ-011 regdst  output  1  write register select: 0 = rt, 1 = rd.
REQ-012 memtoreg  output  1  write-back data select: 0 = ALUOut, 1 = memory data.
REQ-013 regwrite  output  1  register file write enable.
REQ-014 alusrca  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-015 alusrcb  output  2  ALU B select: 00 = B reg, 01 = const 4, 10 = signext imm, 11 = signext imm << 2.
REQ-016 pcsrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-017 alucontrol  output  3  ALU op code; bit2 = invert B and carry-in, bits1:0 = 00 AND, 01 OR, 10 ADD, 11 SLT.
REQ-018 state  output  4  current FSM state encoding, for debug.

Function
REQ-019 Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11; encodings 12-15 go to FETCH on the next edge.
REQ-020 FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, aluop=ADD, pcsrc=00, pcwrite=1; next DECODE.
REQ-021 DECODE: alusrca=0, alusrcb=11, aluop=ADD (branch target into ALUOut); next state by op.
REQ-022 DECODE next state: lw 100011 or sw 101011 -> MEMADR; R-type 000000 -> EXECUTE; beq 000100 -> BEQ; addi 001000 with ADDI_EN=1 -> ADDIEX; j 000010 -> JUMP; any other op -> FETCH.
REQ-023 MEMADR: alusrca=1, alusrcb=10, aluop=ADD; next MEMRD for lw, MEMWR for sw.
REQ-024 MEMRD: iord=1; next MEMWB.  MEMWB: regdst=0, memtoreg=1, regwrite=1; next FETCH.
REQ-025 MEMWR: iord=1, memwrite=1; next FETCH.
REQ-026 EXECUTE: alusrca=1, alusrcb=00, aluop=FUNCT; next ALUWB.  ALUWB: regdst=1, memtoreg=0, regwrite=1; next FETCH.
REQ-027 BEQ: alusrca=1, alusrcb=00, aluop=SUB, pcsrc=01, branch=1; next FETCH.
REQ-028 ADDIEX: alusrca=1, alusrcb=10, aluop=ADD; next ADDIWB.  ADDIWB: regdst=0, memtoreg=0, regwrite=1; next FETCH.
REQ-029 JUMP: pcsrc=10, pcwrite=1; next FETCH.
REQ-030 Outputs not listed for a state are 0; all outputs depend on state and op/funct/zero only, combinationally, and are valid in the same cycle.
REQ-031 pcen = pcwrite OR (branch AND zero), evaluated in the same cycle.
REQ-032 ALU decode: aluop ADD -> 010; SUB -> 110; FUNCT with funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other funct -> 010.
REQ-033 Instruction latency: lw 5 cycles; sw, R-type, addi 4; beq, j 3; unsupported op 2.

Reset
REQ-034 rst_n low forces state=FETCH immediately, independent of clk; outputs then take FETCH values.
REQ-035 If reset is asserted during any state, the instruction in flight is abandoned; a MEMWR or writeback in progress is not completed.
REQ-036 After rst_n deasserts, the first rising edge performs a FETCH and moves to DECODE.

Structure
REQ-037 State encodings, the 2-bit aluop codes (ADD=00, SUB=01, FUNCT=10), opcode constants and funct constants are defined in a shared package also used by the datapath.
REQ-038 One sub-module, aludec, maps aluop and funct to alucontrol; the state register and output decode are in mc_controller.

Verification
REQ-039 Reset pulse mid-EXECUTE -> state=0 asynchronously; next edge state=1; irwrite=1, pcen=1 while in FETCH.
REQ-040 op=100011 -> state trace 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-041 op=000000, funct=101010 -> state 6 drives alucontrol=111, alusrca=1, alusrcb=00; state 7 drives regwrite=1, regdst=1.
REQ-042 op=000100 in state 8: zero=1 -> pcen=1, pcsrc=01, alucontrol=110; zero=0 -> pcen=0.
REQ-043 op=001000 with ADDI_EN=0 -> trace 0,1,0 with no regwrite; with ADDI_EN=1 -> trace 0,1,9,10,0.
REQ-044 op=111111 -> DECODE then FETCH; memwrite and regwrite stay 0 throughout.
